// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: ALU op codes,
// opcodes, mux selects, the FSM state type and the control-word struct.
package mc_pkg;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SLL   = 5'b00001;
    localparam logic [4:0] ALU_SLT   = 5'b00010;
    localparam logic [4:0] ALU_SLTU  = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SRL   = 5'b00101;
    localparam logic [4:0] ALU_OR    = 5'b00110;
    localparam logic [4:0] ALU_AND   = 5'b00111;
    localparam logic [4:0] ALU_SUB   = 5'b01000;
    localparam logic [4:0] ALU_SRA   = 5'b01101;
    localparam logic [4:0] ALU_PASSB = 5'b11111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_JALR   = 2'd1;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd2;
    localparam logic       ADDR_PC       = 1'b0;
    localparam logic       ADDR_ALU      = 1'b1;
    localparam logic [1:0] SRC_A_PC      = 2'd0;
    localparam logic [1:0] SRC_A_RS1     = 2'd1;
    localparam logic [1:0] SRC_A_OLD_PC  = 2'd2;
    localparam logic [1:0] SRC_B_RS2     = 2'd0;
    localparam logic [1:0] SRC_B_IMM     = 2'd1;
    localparam logic [1:0] SRC_B_FOUR    = 2'd2;
    localparam logic [1:0] RES_ALU       = 2'd0;
    localparam logic [1:0] RES_MEM       = 2'd1;
    localparam logic [1:0] RES_PC4       = 2'd2;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, LUI, AUIPC, ADDR, MEM_RD,
        MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, TRAP
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [4:0] alu_op;
        logic       reg_write;
        logic [1:0] result_src;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Single-port memory handshake between the control FSM (master) and memory.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic addr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_src, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_src, output mem_ready);
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// Maps opcode/funct3/funct7[5] to the ALU's 5-bit AluOp for R, I and branch forms.
module alu_op_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [4:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_R:   alu_op = {1'b0, funct7_5, funct3};
            // Immediate forms only honour bit 30 for SRAI; elsewhere it is immediate data.
            OP_I:   alu_op = {1'b0, funct7_5 & (funct3 == 3'b101), funct3};
            OP_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM. Optional retired-instruction counter is
// enabled by defining MC_RETIRE_CNT_EN.
module multicycle_control
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    multicycle_control_if.master mem,
    input  logic                 alu_zero,
    input  logic                 alu_lsb,
    output logic [31:0]          pc_reset_val,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 ir_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [4:0]           alu_op,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic                 trap
`ifdef MC_RETIRE_CNT_EN
    ,
    output logic [31:0]          retired
`endif
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state;
    state_t           next_state;
    logic             rst_hold;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;
    logic             branch_cond;
    logic             branch_taken;
    logic [4:0]       decoded_op;
    ctrl_t            cw;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_op_decode u_alu_op_decode (
        .opcode   (instr[6:0]),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .alu_op   (decoded_op)
    );

    assign waiting      = (state == FETCH || state == MEM_RD || state == MEM_WR) && !mem.mem_ready;
    assign timeout      = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TIMEOUT_LAST);
    assign branch_cond  = instr[14] ? alu_lsb : alu_zero;
    assign branch_taken = (instr[14:13] != 2'b01) && (branch_cond ^ instr[12]);

    // rst_hold keeps outputs quiet for the cycle after reset so a request in
    // flight is dropped one cycle later and nothing is written back.
    always_ff @(posedge clk) begin
        rst_hold <= rst;
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst || rst_hold || !waiting) wait_cnt <= '0;
        else                             wait_cnt <= wait_cnt + CNT_W'(1);
    end

    always_comb begin
        next_state = state;
        if (rst_hold) begin
            next_state = FETCH;
        end else begin
            case (state)
                FETCH:  if (mem.mem_ready) next_state = DECODE; else if (timeout) next_state = TRAP;
                DECODE: begin
                    case (instr[6:0])
                        OP_R:               next_state = EXEC_R;
                        OP_I:               next_state = EXEC_I;
                        OP_LOAD, OP_STORE:  next_state = ADDR;
                        OP_BRANCH:          next_state = BRANCH;
                        OP_JAL:             next_state = JAL;
                        OP_JALR:            next_state = JALR;
                        OP_LUI:             next_state = LUI;
                        OP_AUIPC:           next_state = AUIPC;
                        default:            next_state = TRAP;
                    endcase
                end
                EXEC_R, EXEC_I, LUI, AUIPC: next_state = WB_ALU;
                ADDR:   next_state = (instr[6:0] == OP_STORE) ? MEM_WR : MEM_RD;
                MEM_RD: if (mem.mem_ready) next_state = WB_MEM; else if (timeout) next_state = TRAP;
                MEM_WR: if (mem.mem_ready) next_state = FETCH;  else if (timeout) next_state = TRAP;
                WB_ALU, WB_MEM, BRANCH, JAL, JALR: next_state = FETCH;
                TRAP:    next_state = TRAP;
                default: next_state = FETCH;
            endcase
        end
    end

    always_comb begin
        cw        = '0;
        cw.alu_op = ALU_ADD;
        case (state)
            FETCH: begin
                cw.mem_req   = 1'b1;
                cw.addr_src  = ADDR_PC;
                cw.alu_src_a = SRC_A_PC;
                cw.alu_src_b = SRC_B_FOUR;
                cw.ir_write  = mem.mem_ready;
                cw.pc_write  = mem.mem_ready;
                cw.pc_src    = PC_SRC_ALU;
            end
            // Branch target is formed here so BRANCH can use the ALU for the compare.
            DECODE: begin cw.alu_src_a = SRC_A_OLD_PC; cw.alu_src_b = SRC_B_IMM; end
            EXEC_R: begin cw.alu_src_a = SRC_A_RS1; cw.alu_src_b = SRC_B_RS2; cw.alu_op = decoded_op; end
            EXEC_I: begin cw.alu_src_a = SRC_A_RS1; cw.alu_src_b = SRC_B_IMM; cw.alu_op = decoded_op; end
            LUI:    begin cw.alu_src_b = SRC_B_IMM; cw.alu_op = ALU_PASSB; end
            AUIPC:  begin cw.alu_src_a = SRC_A_OLD_PC; cw.alu_src_b = SRC_B_IMM; end
            ADDR:   begin cw.alu_src_a = SRC_A_RS1; cw.alu_src_b = SRC_B_IMM; end
            MEM_RD: begin cw.mem_req = 1'b1; cw.addr_src = ADDR_ALU; end
            MEM_WR: begin cw.mem_req = 1'b1; cw.addr_src = ADDR_ALU; cw.mem_we = 1'b1; end
            WB_ALU: begin cw.reg_write = 1'b1; cw.result_src = RES_ALU; end
            WB_MEM: begin cw.reg_write = 1'b1; cw.result_src = RES_MEM; end
            BRANCH: begin
                cw.alu_src_a = SRC_A_RS1;
                cw.alu_src_b = SRC_B_RS2;
                cw.alu_op    = decoded_op;
                cw.pc_write  = branch_taken;
                cw.pc_src    = PC_SRC_BRANCH;
            end
            JAL: begin
                cw.reg_write = 1'b1; cw.result_src = RES_PC4;
                cw.pc_write  = 1'b1; cw.pc_src     = PC_SRC_BRANCH;
            end
            JALR: begin
                cw.alu_src_a = SRC_A_RS1; cw.alu_src_b = SRC_B_IMM;
                cw.reg_write = 1'b1; cw.result_src = RES_PC4;
                cw.pc_write  = 1'b1; cw.pc_src     = PC_SRC_JALR;
            end
            TRAP:    cw.trap = 1'b1;
            default: cw = '0;
        endcase
        if (rst_hold) cw = '0;
    end

    assign pc_reset_val = RESET_PC;
    assign pc_write     = cw.pc_write;
    assign pc_src       = cw.pc_src;
    assign ir_write     = cw.ir_write;
    assign mem.mem_req  = cw.mem_req;
    assign mem.mem_we   = cw.mem_we;
    assign mem.addr_src = cw.addr_src;
    assign alu_src_a    = cw.alu_src_a;
    assign alu_src_b    = cw.alu_src_b;
    assign alu_op       = cw.alu_op;
    assign reg_write    = cw.reg_write;
    assign result_src   = cw.result_src;
    assign trap         = cw.trap;

`ifdef MC_RETIRE_CNT_EN
    logic retire_evt;
    assign retire_evt = !rst_hold && (next_state == FETCH) &&
                        (state inside {WB_ALU, WB_MEM, MEM_WR, BRANCH, JAL, JALR});

    always_ff @(posedge clk) begin
        if (rst)             retired <= '0;
        else if (retire_evt) retired <= retired + 32'd1;
    end
`endif

endmodule
